// File: rtl/btn_bank_conditioner.sv
// Multi-channel push-button conditioner: synchronise, debounce, edge detect,
// long-press detection and auto-repeat, one independent lane per button.
module btn_bank_conditioner #(
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int COUNT        = 16,
  parameter int HOLD_COUNT   = 1000,
  parameter int REPEAT_COUNT = 250,
  parameter int REPEAT_EN    = 1,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] rpt,
  output logic                any_rise
);

  localparam int CW = $clog2(COUNT + 1);
  localparam int HW = $clog2(HOLD_COUNT + 1);
  localparam int RW = $clog2(REPEAT_COUNT + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(COUNT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_COUNT);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(HOLD_COUNT - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_COUNT - 1);
  localparam logic          INV       = (ACTIVE_LOW != 0);
  localparam logic          RPT_ON    = (REPEAT_EN != 0);

  logic [CHANNELS-1:0] rise_d;
  logic                any_rise_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [RW-1:0]          rep_q, rep_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_n;
    logic                   fall_q, fall_d;
    logic                   long_q, long_d;
    logic                   rpt_q, rpt_d;
    logic                   s;

    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], btn[c] ^ INV};
      s      = sync_q[SYNC_STAGES-1];

      out_d = out_q;
      cnt_d = '0;
      if (s != out_q) begin
        if (cnt_q == CNT_LAST) begin
          out_d = s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      rise_n = out_d & ~out_q;
      fall_d = ~out_d & out_q;

      // hold_q saturates at HOLD_COUNT; from then on rep_q paces rpt
      hold_d = '0;
      rep_d  = '0;
      long_d = 1'b0;
      rpt_d  = 1'b0;
      if (out_d) begin
        if (!out_q) begin
          hold_d = HOLD_ONE;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
          long_d = (hold_q == HOLD_PRE);
        end else begin
          hold_d = hold_q;
          rep_d  = (rep_q == RPT_LAST) ? '0 : rep_q + 1'b1;
          rpt_d  = RPT_ON && (rep_q == RPT_LAST);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q <= '0;
        cnt_q  <= '0;
        hold_q <= '0;
        rep_q  <= '0;
        out_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        long_q <= 1'b0;
        rpt_q  <= 1'b0;
      end else begin
        sync_q <= sync_d;
        cnt_q  <= cnt_d;
        hold_q <= hold_d;
        rep_q  <= rep_d;
        out_q  <= out_d;
        rise_q <= rise_n;
        fall_q <= fall_d;
        long_q <= long_d;
        rpt_q  <= rpt_d;
      end
    end

    assign rise_d[c]     = rise_n;
    assign out[c]        = out_q;
    assign rise[c]       = rise_q;
    assign fall[c]       = fall_q;
    assign long_press[c] = long_q;
    assign rpt[c]        = rpt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      any_rise_q <= 1'b0;
    end else begin
      any_rise_q <= |rise_d;
    end
  end

  assign any_rise = any_rise_q;

endmodule

// File: tb/tb_btn_bank_conditioner.sv
// Bench for btn_bank_conditioner: directed table, corner sequences,
// and random stimulus against a cycle-count reference model.
module tb_btn_bank_conditioner;
  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int CNT  = 3;
  localparam int HOLD = 8;
  localparam int RPT  = 4;

  typedef struct {
    logic        rst;
    logic [3:0]  b;
    int          n;
    logic [20:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] btn = '0;
  logic [CH-1:0] btn_n = '1;
  logic [CH-1:0] out, rise, fall, long_press, rpt;
  logic          any_rise;
  logic [CH-1:0] a_out, a_rise, a_fall, a_long, a_rpt;
  logic          a_any;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  btn_bank_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .COUNT(CNT),
    .HOLD_COUNT(HOLD), .REPEAT_COUNT(RPT),
    .REPEAT_EN(1), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn),
    .out(out), .rise(rise), .fall(fall),
    .long_press(long_press), .rpt(rpt), .any_rise(any_rise)
  );

  btn_bank_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .COUNT(CNT),
    .HOLD_COUNT(HOLD), .REPEAT_COUNT(RPT),
    .REPEAT_EN(1), .ACTIVE_LOW(1)
  ) dut_al (
    .clk(clk), .reset(reset), .btn(btn_n),
    .out(a_out), .rise(a_rise), .fall(a_fall),
    .long_press(a_long), .rpt(a_rpt), .any_rise(a_any)
  );

  // Reference: s is the pin as seen SYNC edges ago; out flips after a
  // run of CNT disagreeing samples; age counts cycles since the press.
  bit            m_hist[CH][$];
  int            m_run[CH];
  int            m_age[CH];
  logic [CH-1:0] m_out = '0, m_rise = '0, m_fall = '0;
  logic [CH-1:0] m_long = '0, m_rpt = '0;
  logic          m_any = 1'b0;

  task automatic model_step();
    bit s;
    for (int c = 0; c < CH; c++) begin
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      m_long[c] = 1'b0;
      m_rpt[c]  = 1'b0;
      if (reset) begin
        m_hist[c].delete();
        for (int j = 0; j < SYNC; j++) m_hist[c].push_back(1'b0);
        m_out[c] = 1'b0;
        m_run[c] = 0;
        m_age[c] = -1;
      end else begin
        s = m_hist[c][SYNC-1];
        m_hist[c].push_front(btn[c]);
        void'(m_hist[c].pop_back());
        if (s != m_out[c]) begin
          m_run[c]++;
          if (m_run[c] == CNT) begin
            m_out[c] = s;
            m_run[c] = 0;
            if (s) m_rise[c] = 1'b1;
            else   m_fall[c] = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
        if (m_out[c]) begin
          m_age[c]  = m_rise[c] ? 0 : m_age[c] + 1;
          m_long[c] = (m_age[c] == HOLD - 1);
          m_rpt[c]  = (m_age[c] > HOLD - 1) &&
                      ((m_age[c] - (HOLD - 1)) % RPT == 0);
        end else begin
          m_age[c] = -1;
        end
      end
    end
    m_any = |m_rise;
  endtask

  function automatic logic [20:0] dut_vec();
    return {out, rise, fall, long_press, rpt, any_rise};
  endfunction

  function automatic logic [20:0] model_vec();
    return {m_out, m_rise, m_fall, m_long, m_rpt, m_any};
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] b,
                              input int n, input logic [3:0] o,
                              input logic [3:0] ri, input logic [3:0] fa,
                              input logic [3:0] lo, input logic [3:0] rp,
                              input logic an);
    vec_t v;
    v.rst = r;
    v.b   = b;
    v.n   = n;
    v.exp = {o, ri, fa, lo, rp, an};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model", 32'(dut_vec()), 32'(model_vec()));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[$];
    logic       flag;
    logic [3:0] lvl;

    tbl.push_back(mk(1, 4'h0,  2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 4'h0, 20, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 4'h1,  4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 4'h1,  1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 4'h1,  1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 4'h1,  6, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 0));
    tbl.push_back(mk(0, 4'h1,  4, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 0));
    tbl.push_back(mk(0, 4'h1,  3, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 4'h1,  1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 0));
    tbl.push_back(mk(0, 4'h0,  4, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 0));
    tbl.push_back(mk(0, 4'h0,  1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 4'h0,  3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst;
      btn   = tbl[i].b;
      repeat (tbl[i].n) tick();
      chk($sformatf("tbl%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
    end

    // bounce on channel 1: 2-sample runs never reach CNT
    btn  = '0;
    flag = 1'b0;
    for (int k = 0; k < 5; k++) begin
      btn[1] = 1'b1;
      repeat (2) begin tick(); if (out[1]) flag = 1'b1; end
      btn[1] = 1'b0;
      repeat (2) begin tick(); if (out[1]) flag = 1'b1; end
    end
    chk("bounce_quiet", 32'(flag), 0);
    btn[1] = 1'b1;
    flag   = 1'b0;
    repeat (4) begin tick(); if (rise[1]) flag = 1'b1; end
    chk("bounce_early", 32'(flag), 0);
    tick();
    chk("bounce_rise", 32'({out[1], rise[1], any_rise}), 3'b111);
    btn = '0;
    repeat (10) tick();

    // short press on channel 2
    btn[2] = 1'b1;
    for (int k = 0; k < 12 && !rise[2]; k++) tick();
    chk("sp_rise", 32'(rise[2]), 1);
    btn[2] = 1'b0;
    flag   = 1'b0;
    repeat (4) begin
      tick();
      if (fall[2] | long_press[2] | rpt[2]) flag = 1'b1;
    end
    chk("sp_early", 32'(flag), 0);
    tick();
    chk("sp_fall", 32'({fall[2], long_press[2], rpt[2]}), 3'b100);
    repeat (4) tick();

    // reset while channels 0 and 3 are held past long_press
    btn = 4'b1001;
    for (int k = 0; k < 30 && !long_press[0]; k++) tick();
    chk("rs_long", 32'(long_press), 4'b1001);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("rs_clear", 32'(dut_vec()), 0);
    reset = 1'b0;
    flag  = 1'b0;
    repeat (4) begin
      tick();
      if (any_rise | (|rise)) flag = 1'b1;
    end
    chk("rs_early", 32'(flag), 0);
    tick();
    chk("rs_rise", 32'({rise, any_rise}), 5'b10011);
    tick();
    chk("rs_any_once", 32'(any_rise), 0);
    btn = '0;
    repeat (8) tick();

    // active-low instance
    chk("al_idle", 32'({a_out, a_rise, a_fall}), 0);
    btn_n[0] = 1'b0;
    flag     = 1'b0;
    repeat (4) begin tick(); if (a_rise[0] | a_out[0]) flag = 1'b1; end
    chk("al_early", 32'(flag), 0);
    tick();
    chk("al_rise", 32'({a_out[0], a_rise[0]}), 2'b11);
    repeat (5) tick();
    btn_n[0] = 1'b1;
    flag     = 1'b0;
    repeat (4) begin tick(); if (a_fall[0] | !a_out[0]) flag = 1'b1; end
    chk("al_fall_early", 32'(flag), 0);
    tick();
    chk("al_fall", 32'({a_out[0], a_fall[0]}), 2'b01);

    // random press/bounce/reset traffic against the model
    lvl = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(11) == 0) lvl[c] = ~lvl[c];
      end
      btn = lvl;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(19) == 0) btn[c] = ~btn[c];
      end
      reset = ($urandom_range(499) == 0);
      tick();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
